// File: rtl/wb_multichannel_counter.sv
// wb_multichannel_counter: CHANNELS independent BITS-wide counters behind a
// simple valid/wstrb/ready Wishbone slave. Each channel has an enable,
// an up/down direction, a compare register with a sticky match flag, optional
// auto-reload and an interrupt enable. Channel 0 COUNT can be overridden bit by
// bit from the logic analyser. Register reads are zero-extended to 32 bits.
`timescale 1ns/1ps

module wb_multichannel_counter #(
    parameter int CHANNELS = 4,
    parameter int BITS     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid,
    input  logic [3:0]               wstrb,
    input  logic [7:0]               adr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic                     ready,
    input  logic [BITS-1:0]          la_write,
    input  logic [BITS-1:0]          la_input,
    output logic [CHANNELS*BITS-1:0] count,
    output logic                     irq
);

    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_COUNT   = 2'd1,
        REG_COMPARE = 2'd2,
        REG_STATUS  = 2'd3
    } reg_sel_e;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_DIR    = 1;
    localparam int CTRL_RELOAD = 2;
    localparam int CTRL_IRQ_EN = 3;

    // Bus state
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;

    // Per-channel registers
    logic [3:0]      ctrl_q    [CHANNELS];
    logic [3:0]      ctrl_d    [CHANNELS];
    logic [BITS-1:0] count_q   [CHANNELS];
    logic [BITS-1:0] count_d   [CHANNELS];
    logic [BITS-1:0] compare_q [CHANNELS];
    logic [BITS-1:0] compare_d [CHANNELS];
    logic [CHANNELS-1:0] match_q, match_d;

    // Per-channel decode and step results
    logic [CHANNELS-1:0] ch_sel;
    logic [CHANNELS-1:0] count_wr;
    logic [CHANNELS-1:0] hit;
    logic [BITS-1:0]     step_val [CHANNELS];

    logic        commit;
    logic        wr_en;
    logic [3:0]  ch_idx;
    reg_sel_e    reg_sel;
    logic [31:0] rd_val;

    // Byte-address bits [1:0] carry no information for word registers.
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^adr[1:0];

    // A transfer commits on the edge that raises ready; a second cycle
    // of the same request sees ready high and is not committed again.
    assign commit  = valid & ~ready_q;
    assign wr_en   = commit & (|wstrb);
    assign ch_idx  = adr[7:4];
    assign reg_sel = reg_sel_e'(adr[3:2]);

    // Replace the bytes of old_v selected by strb with the matching bytes of new_v.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_v[8*b +: 8];
        end
        return merged;
    endfunction

    // Channel select, COUNT-write detect and the counter step for each channel.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first, otherwise
        // a path that skips the assignment infers a latch.
        ch_sel   = '0;
        count_wr = '0;
        hit      = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            step_val[i] = count_q[i];
            ch_sel[i]   = commit && (ch_idx == 4'(i));
            count_wr[i] = wr_en && ch_sel[i] && (reg_sel == REG_COUNT);
            if (ctrl_q[i][CTRL_DIR]) begin
                if (count_q[i] == '0) begin
                    hit[i]      = 1'b1;
                    step_val[i] = ctrl_q[i][CTRL_RELOAD] ? compare_q[i]
                                                         : count_q[i] - BITS'(1);
                end else begin
                    step_val[i] = count_q[i] - BITS'(1);
                end
            end else begin
                if (count_q[i] == compare_q[i]) begin
                    hit[i]      = 1'b1;
                    step_val[i] = ctrl_q[i][CTRL_RELOAD] ? '0 : count_q[i] + BITS'(1);
                end else begin
                    step_val[i] = count_q[i] + BITS'(1);
                end
            end
            // Match only counts while enabled and not overwritten by the bus.
            hit[i] = hit[i] & ctrl_q[i][CTRL_EN] & ~count_wr[i];
        end
    end

    // Register next-state: step, bus writes, LA override, read mux and irq.
    always_comb begin
        ready_d = valid & ~ready_q;
        rdata_d = rdata_q;
        rd_val  = '0;
        irq_d   = 1'b0;
        match_d = match_q;
        for (int i = 0; i < CHANNELS; i++) begin
            ctrl_d[i]    = ctrl_q[i];
            compare_d[i] = compare_q[i];
            count_d[i]   = count_q[i];

            if (ctrl_q[i][CTRL_EN]) count_d[i] = step_val[i];
            if (count_wr[i]) begin
                count_d[i] = BITS'(byte_merge(32'(count_q[i]), wdata, wstrb));
            end

            if (wr_en && ch_sel[i]) begin
                case (reg_sel)
                    REG_CTRL:    ctrl_d[i] = 4'(byte_merge({28'b0, ctrl_q[i]}, wdata, wstrb));
                    REG_COMPARE: compare_d[i] = BITS'(byte_merge(32'(compare_q[i]), wdata, wstrb));
                    REG_STATUS:  if (wstrb[0] && wdata[0]) match_d[i] = 1'b0;
                    default:     ;
                endcase
            end
            // A new match in the same cycle as a clear wins.
            if (hit[i]) match_d[i] = 1'b1;

            if (ch_sel[i]) begin
                case (reg_sel)
                    REG_CTRL:    rd_val = {28'b0, ctrl_q[i]};
                    REG_COUNT:   rd_val = 32'(count_q[i]);
                    REG_COMPARE: rd_val = 32'(compare_q[i]);
                    REG_STATUS:  rd_val = {31'b0, match_q[i]};
                    default:     rd_val = '0;
                endcase
            end

            irq_d = irq_d | (match_q[i] & ctrl_q[i][CTRL_IRQ_EN]);
        end

        // LA override has the final say on channel 0 COUNT, bit by bit.
        count_d[0] = (count_d[0] & ~la_write) | (la_input & la_write);

        if (commit) rdata_d = rd_val;
    end

    // State registers, all cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
            match_q <= '0;
            // NOTE: the per-channel arrays are a handful of flops, not a RAM, so they
            // are reset element by element like any other register.
            for (int i = 0; i < CHANNELS; i++) begin
                ctrl_q[i]    <= '0;
                count_q[i]   <= '0;
                compare_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge value, independent of statement order.
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
            match_q <= match_d;
            for (int i = 0; i < CHANNELS; i++) begin
                ctrl_q[i]    <= ctrl_d[i];
                count_q[i]   <= count_d[i];
                compare_q[i] <= compare_d[i];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_count_out
            assign count[g*BITS +: BITS] = count_q[g];
        end
    endgenerate

    assign ready = ready_q;
    assign rdata = rdata_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_wb_multichannel_counter.sv
// Directed testbench for wb_multichannel_counter (CHANNELS=4, BITS=32).
// Each scenario task drives the bus and compares outputs inline against
// hand-computed values. Outputs are sampled 1 ns after the rising edge.
`timescale 1ns/1ps

module tb_wb_multichannel_counter;

    localparam int CHANNELS = 4;
    localparam int BITS     = 32;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     valid;
    logic [3:0]               wstrb;
    logic [7:0]               adr;
    logic [31:0]              wdata;
    logic [31:0]              rdata;
    logic                     ready;
    logic [BITS-1:0]          la_write;
    logic [BITS-1:0]          la_input;
    logic [CHANNELS*BITS-1:0] count;
    logic                     irq;

    int errors = 0;
    int checks = 0;

    wb_multichannel_counter #(.CHANNELS(CHANNELS), .BITS(BITS)) dut (
        .clk      (clk),
        .reset    (reset),
        .valid    (valid),
        .wstrb    (wstrb),
        .adr      (adr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .la_write (la_write),
        .la_input (la_input),
        .count    (count),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] cnt(input int ch);
        return count[ch*BITS +: BITS];
    endfunction

    // One bus transfer; waits at most 4 edges for the acknowledge.
    task automatic wb_cycle(input logic [7:0] a, input logic [3:0] s,
                            input logic [31:0] d, output logic [31:0] r);
        bit acked;
        acked = 1'b0;
        adr   = a;
        wstrb = s;
        wdata = d;
        valid = 1'b1;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) acked = 1'b1;
        end
        r     = rdata;
        valid = 1'b0;
        wstrb = 4'h0;
        checks++;
        if (!acked) begin
            errors++;
            $display("FAIL ack adr=%h: ready never seen, required within 4 cycles", a);
        end
    endtask

    task automatic wb_write(input logic [7:0] a, input logic [3:0] s,
                            input logic [31:0] d, output logic [31:0] r);
        wb_cycle(a, s, d, r);
    endtask

    task automatic wb_read(input logic [7:0] a, output logic [31:0] r);
        wb_cycle(a, 4'h0, 32'h0, r);
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        valid    = 1'b0;
        wstrb    = 4'h0;
        adr      = 8'h0;
        wdata    = 32'h0;
        la_write = '0;
        la_input = '0;
        #12;
        checks++;
        if ({ready, rdata, count, irq} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rdata=%h count=%h irq=%b, required all 0",
                     ready, rdata, count, irq);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_up_no_reload;
        logic [31:0] r;
        wb_write(8'h18, 4'hF, 32'd5, r);
        wb_write(8'h10, 4'hF, 32'h9, r);
        checks++;
        if (cnt(1) !== 32'd0) begin
            errors++;
            $display("FAIL up_start: count=%h required 0", cnt(1));
        end
        // Count passes 5, match latches on the edge after 5, irq one edge later.
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (cnt(1) !== 32'(k)) begin
                errors++;
                $display("FAIL up_count step %0d: count=%h required %h", k, cnt(1), 32'(k));
            end
            checks++;
            if (irq !== (k >= 7)) begin
                errors++;
                $display("FAIL up_irq step %0d: irq=%b required %b", k, irq, (k >= 7));
            end
        end
        wb_read(8'h1C, r);
        checks++;
        if (r !== 32'd1) begin
            errors++;
            $display("FAIL up_status: got %h required 1", r);
        end
        wb_write(8'h1C, 4'h1, 32'h1, r);
        checks++;
        if (r !== 32'd1) begin
            errors++;
            $display("FAIL up_w1c_prewrite: rdata=%h required 1", r);
        end
        @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL up_irq_clear: irq=%b required 0", irq);
        end
        wb_write(8'h10, 4'hF, 32'h0, r);
        wb_read(8'h1C, r);
        checks++;
        if (r !== 32'd0) begin
            errors++;
            $display("FAIL up_status_cleared: got %h required 0", r);
        end
    endtask

    task automatic test_down_reload;
        logic [31:0] r;
        logic [31:0] exp_seq [5];
        exp_seq = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3};
        wb_write(8'h28, 4'hF, 32'd3, r);
        wb_write(8'h24, 4'hF, 32'd0, r);
        wb_write(8'h20, 4'hF, 32'h7, r);
        checks++;
        if (cnt(2) !== 32'd0) begin
            errors++;
            $display("FAIL down_start: count=%h required 0", cnt(2));
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (cnt(2) !== exp_seq[k]) begin
                errors++;
                $display("FAIL down_seq step %0d: count=%h required %h", k, cnt(2), exp_seq[k]);
            end
        end
        wb_write(8'h20, 4'hF, 32'h0, r);
        wb_read(8'h2C, r);
        checks++;
        if (r !== 32'd1) begin
            errors++;
            $display("FAIL down_status: got %h required 1", r);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL down_irq: irq=%b required 0 with irq_en clear", irq);
        end
        wb_write(8'h2C, 4'h1, 32'h1, r);
        wb_read(8'h2C, r);
        checks++;
        if (r !== 32'd0) begin
            errors++;
            $display("FAIL down_w1c: got %h required 0", r);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] r;
        wb_write(8'h08, 4'hF, 32'h10, r);
        wb_write(8'h04, 4'hF, 32'hFFFF_FFFF, r);
        wb_write(8'h00, 4'hF, 32'h1, r);
        checks++;
        if (cnt(0) !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_start: count=%h required ffffffff", cnt(0));
        end
        @(posedge clk);
        #1;
        checks++;
        if (cnt(0) !== 32'h0) begin
            errors++;
            $display("FAIL wrap_up: count=%h required 0", cnt(0));
        end
        wb_read(8'h0C, r);
        checks++;
        if (r !== 32'd0) begin
            errors++;
            $display("FAIL wrap_no_match: status=%h required 0", r);
        end
        wb_write(8'h00, 4'hF, 32'h0, r);
        wb_write(8'h04, 4'hF, 32'h0, r);
        wb_write(8'h00, 4'hF, 32'h3, r);
        checks++;
        if (cnt(0) !== 32'h0) begin
            errors++;
            $display("FAIL wrap_down_start: count=%h required 0", cnt(0));
        end
        @(posedge clk);
        #1;
        checks++;
        if (cnt(0) !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_down: count=%h required ffffffff", cnt(0));
        end
        wb_write(8'h00, 4'hF, 32'h0, r);
    endtask

    task automatic test_priority;
        logic [31:0] r;
        la_write = 32'h0000_00FF;
        la_input = 32'h0000_00AB;
        wb_write(8'h04, 4'hF, 32'h1234_5600, r);
        checks++;
        if (cnt(0) !== 32'h1234_56AB) begin
            errors++;
            $display("FAIL prio_la_wb: count=%h required 123456ab", cnt(0));
        end
        la_write = '0;
        la_input = '0;
        @(posedge clk);
        #1;
        checks++;
        if (cnt(0) !== 32'h1234_56AB) begin
            errors++;
            $display("FAIL prio_hold: count=%h required 123456ab", cnt(0));
        end
        // ch3: up, reload, compare 0 -> matches on every enabled cycle.
        wb_write(8'h30, 4'hF, 32'h5, r);
        wb_write(8'h3C, 4'h1, 32'h1, r);
        wb_read(8'h3C, r);
        checks++;
        if (r !== 32'd1) begin
            errors++;
            $display("FAIL prio_set_wins: status=%h required 1", r);
        end
        checks++;
        if (cnt(3) !== 32'd0) begin
            errors++;
            $display("FAIL prio_reload_hold: count=%h required 0", cnt(3));
        end
        wb_write(8'h30, 4'hF, 32'h0, r);
        wb_write(8'h3C, 4'h1, 32'h1, r);
        wb_read(8'h3C, r);
        checks++;
        if (r !== 32'd0) begin
            errors++;
            $display("FAIL prio_w1c_idle: status=%h required 0", r);
        end
    endtask

    task automatic test_bus;
        logic [31:0] r;
        @(posedge clk);
        #1;
        adr   = 8'h00;
        wstrb = 4'h0;
        valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (ready !== ((k % 2) == 0)) begin
                errors++;
                $display("FAIL hs_ready edge %0d: ready=%b required %b", k, ready, ((k % 2) == 0));
            end
        end
        valid = 1'b0;
        @(posedge clk);
        #1;
        wb_write(8'h18, 4'b0010, 32'hAABB_CCDD, r);
        checks++;
        if (r !== 32'd5) begin
            errors++;
            $display("FAIL byte_prewrite: rdata=%h required 5", r);
        end
        wb_read(8'h18, r);
        checks++;
        if (r !== 32'h0000_CC05) begin
            errors++;
            $display("FAIL byte_write: compare=%h required 0000cc05", r);
        end
        wb_write(8'hF4, 4'hF, 32'hDEAD_BEEF, r);
        checks++;
        if (r !== 32'd0) begin
            errors++;
            $display("FAIL ch15_write_rdata: got %h required 0", r);
        end
        wb_read(8'hF4, r);
        checks++;
        if (r !== 32'd0) begin
            errors++;
            $display("FAIL ch15_read: got %h required 0", r);
        end
        checks++;
        if (cnt(0) !== 32'h1234_56AB) begin
            errors++;
            $display("FAIL ch15_no_alias: ch0 count=%h required 123456ab", cnt(0));
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] r;
        wb_write(8'h30, 4'hF, 32'hD, r);
        wb_write(8'h10, 4'hF, 32'h1, r);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_irq: irq=%b required 1", irq);
        end
        adr   = 8'h14;
        wstrb = 4'h0;
        valid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b1 || rdata === 32'd0) begin
            errors++;
            $display("FAIL rst_pre_read: ready=%b rdata=%h required ready=1 rdata!=0", ready, rdata);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({ready, rdata, count, irq} !== '0) begin
            errors++;
            $display("FAIL rst_async: ready=%b rdata=%h count=%h irq=%b, required all 0",
                     ready, rdata, count, irq);
        end
        valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            for (int rg = 0; rg < 4; rg++) begin
                wb_read(8'(ch * 16 + rg * 4), r);
                checks++;
                if (r !== 32'd0) begin
                    errors++;
                    $display("FAIL rst_regs ch%0d reg%0d: got %h required 0", ch, rg, r);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_up_no_reload;
        test_down_reload;
        test_wrap;
        test_priority;
        test_bus;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_multichannel_counter.md
Name: wb_multichannel_counter

Overview:
- Parametrised successor to the single Wishbone-controlled counter in the user project.
- Provides CHANNELS independent BITS-wide counters, each with:
  - enable and up/down direction
  - a compare register with sticky match flag
  - optional auto-reload
- Sits behind the user-area Wishbone slave glue (valid/wstrb/ready/rdata).
- Channel counts drive io/LA outputs; a combined interrupt drives user irq.

Parameters:
- CHANNELS, 4, number of counter channels (1..16).
- BITS, 32, counter/compare width (8..32); register reads zero-extend to 32.

Ports:
- clk  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-high reset.
- valid  input  1  Wishbone cycle request (cyc & stb).
- wstrb  input  4  byte write strobes; all-zero means read.
- adr  input  8  byte address; [7:4] channel, [3:2] register, [1:0] ignored.
- wdata  input  32  write data.
- rdata  output  32  registered read data, valid while ready=1.
- ready  output  1  one-cycle acknowledge.
- la_write  input  BITS  per-bit LA override enable, channel 0 COUNT only.
- la_input  input  BITS  LA override value.
- count  output  CHANNELS*BITS  all COUNT registers; channel n at [n*BITS +: BITS].
- irq  output  1  OR over channels of (STATUS.match & CTRL.irq_en).

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. In reset, all registers and outputs are 0: ready=0, rdata=0, count=0, irq=0.

Register map (per channel):
- 0x0 CTRL: [0] en, [1] dir (0 up, 1 down), [2] reload, [3] irq_en; other bits read 0.
- 0x4 COUNT.
- 0x8 COMPARE.
- 0xC STATUS: [0] match, write-1-to-clear.

Wishbone handshake:
- ready <= valid & ~ready.
- Ack arrives exactly 1 cycle after valid rises. ready is low for 1 cycle before a back-to-back transaction can be acked.
- Writes commit on the same edge that raises ready. Bytes are gated by wstrb; bytes above BITS are ignored.
- rdata is loaded on that same edge with the pre-write register value. It holds until the next ack.
- Channel index >= CHANNELS: read 0, write ignored, still acked.

Counter step (each cycle, per channel, en=1):
- Up: match = (count == compare).
  - If match & reload: next = 0.
  - Otherwise: next = count+1, wrapping modulo 2^BITS.
- Down: match = (count == 0).
  - If match & reload: next = compare.
  - Otherwise: next = count-1, wrapping to all-ones.
- match sets STATUS.match sticky. Match is evaluated only when en=1.
- en=0 holds count; no match is detected.

Priority on COUNT (per bit):
1. LA override (channel 0 only, where la_write=1).
2. Wishbone write to COUNT.
3. Step.

Simultaneous events:
- A Wishbone COUNT write that cycle suppresses match detection for that channel.
- STATUS set and W1C clear in the same cycle: set wins.
- A CTRL write takes effect the cycle after commit; the commit cycle uses the old CTRL.

Interrupt:
- irq is registered: asserts the cycle after match is set, provided irq_en=1.
- irq deasserts the cycle after clear, or after irq_en is written to 0.

Reset mid-transaction:
- ready drops immediately and nothing commits.
- The master must reissue the transaction.

Test Plan:
- Reset: assert reset mid-count, with a read pending. Required: count=0, ready=0, rdata=0, irq=0 asynchronously; all regs read 0 after release.
- Up, no reload: ch1 COMPARE=5, CTRL=0x9. Required: count 0..5, match and irq set 1 cycle after count==5; count continues 6,7,...; W1C STATUS clears irq next cycle.
- Down, reload: ch2 COMPARE=3, COUNT=0, CTRL=0x7. Required: sequence 0,3,2,1,0,3; match set at each 0.
- Wrap: ch0 COUNT=0xFFFF_FFFF, up, en, COMPARE=0x10. Required: next 0, no match. Down from 0 without reload gives 0xFFFF_FFFF.
- Priority: la_write=0x0000_00FF, la_input=0xAB, simultaneous WB COUNT write 0x1234_5600 to ch0. Required: COUNT=0x1234_56AB. Also: match set with same-cycle W1C leaves match=1.
- Handshake/bus: valid held 4 cycles. Required: ready pattern 0,1,0,1. Byte write wstrb=0010 changes only bits [15:8]. Access to channel 15 with CHANNELS=4 acks and reads 0.
